// File: rtl/dmem_io_pkg.sv
// Shared constants and helpers for the data-memory / IO device: IO window offsets
// and the 7-segment hex decoder.
package dmem_io_pkg;

    localparam int unsigned DISP_OFS   = 0;
    localparam int unsigned SWLVL_OFS  = 1;
    localparam int unsigned SWEDGE_OFS = 2;
    localparam int unsigned TIMER_OFS  = 3;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ZERO  = 7'h3F;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_BLANK;
        case (nib)
            4'h0: s = SEG_ZERO;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a stable-count debouncer.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_async,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The last stable cycle updates the level directly, so the counter never holds DEBOUNCE_CYCLES.
    always_comb begin
        sync1_d = sw_async;
        sync2_d = sync1_q;
        cnt_d   = '0;
        lvl_d   = lvl_q;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
        end
    end

    assign level = lvl_q;

endmodule

// File: rtl/dmem_io_multi.sv
// Word RAM plus IO window (display, switch levels/edges, optional timer) driving a
// scanned hex display. Define IO_TIMER_EN to build the free-running timer at IO_BASE+3.
module dmem_io_multi
    import dmem_io_pkg::*;
#(
    parameter int unsigned      DATA_W          = 16,
    parameter int unsigned      ADDR_W          = 16,
    parameter int unsigned      RAM_DEPTH       = 128,
    parameter int unsigned      NUM_SW          = 4,
    parameter int unsigned      NUM_DIGITS      = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 4,
    parameter int unsigned      SCAN_DIV        = 1024,
    parameter logic [ADDR_W-1:0] IO_BASE        = 16'hFFF0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  wen,
    input  logic                  ren,
    output logic [DATA_W-1:0]     rdata,
    input  logic [NUM_SW-1:0]     sw,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
    localparam int unsigned DISP_W = 4 * NUM_DIGITS;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic [DISP_W-1:0] disp_q, disp_d;
    logic [NUM_SW-1:0] sw_lvl;
    logic [NUM_SW-1:0] lvl_prev_q, lvl_prev_d;
    logic [NUM_SW-1:0] edge_q, edge_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] io_ofs;
    logic [1:0]        io_sel;
    logic              ram_hit, io_hit;
    logic              ram_we, wr_disp, wr_edge;
    logic [3:0]        nib;
`ifdef IO_TIMER_EN
    logic [15:0]       timer_q, timer_d;
    logic              wr_timer;
`endif

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clock    (clock),
            .reset    (reset),
            .sw_async (sw[i]),
            .level    (sw_lvl[i])
        );
    end

    assign ram_hit = addr < ADDR_W'(RAM_DEPTH);
    assign io_ofs  = addr - IO_BASE;
    assign io_hit  = (addr >= IO_BASE) && (io_ofs < ADDR_W'(4));
    assign io_sel  = io_ofs[1:0];
    assign ram_we  = wen && ram_hit;
    assign wr_disp = wen && io_hit && (io_sel == 2'(DISP_OFS));
    assign wr_edge = wen && io_hit && (io_sel == 2'(SWEDGE_OFS));
`ifdef IO_TIMER_EN
    assign wr_timer = wen && io_hit && (io_sel == 2'(TIMER_OFS));
`endif

    // Read mux sees only current register state, so same-cycle writes return the old value.
    always_comb begin
        rdata = '0;
        if (ren) begin
            if (ram_hit) begin
                rdata = ram_q[addr[RAM_AW-1:0]];
            end else if (io_hit) begin
                case (io_sel)
                    2'(DISP_OFS):   rdata = DATA_W'(disp_q);
                    2'(SWLVL_OFS):  rdata = DATA_W'(sw_lvl);
                    2'(SWEDGE_OFS): rdata = DATA_W'(edge_q);
`ifdef IO_TIMER_EN
                    2'(TIMER_OFS):  rdata = DATA_W'(timer_q);
`endif
                    default:        rdata = '0;
                endcase
            end
        end
    end

    // Register next-state: display, edge flags (set beats clear), scan counter, timer.
    always_comb begin
        disp_d     = disp_q;
        lvl_prev_d = sw_lvl;
        edge_d     = edge_q;
        scan_d     = scan_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (wr_disp) begin
            disp_d = wdata[DISP_W-1:0];
        end
        if (wr_edge) begin
            edge_d = edge_q & ~wdata[NUM_SW-1:0];
        end
        edge_d = edge_d | (sw_lvl & ~lvl_prev_q);
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            if (NUM_DIGITS > 1) begin
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
        end
`ifdef IO_TIMER_EN
        timer_d = wr_timer ? wdata[15:0] : timer_q + 16'd1;
`endif
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_q[addr[RAM_AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            disp_q     <= '0;
            lvl_prev_q <= '0;
            edge_q     <= '0;
            scan_q     <= '0;
            idx_q      <= '0;
`ifdef IO_TIMER_EN
            timer_q    <= '0;
`endif
        end else begin
            disp_q     <= disp_d;
            lvl_prev_q <= lvl_prev_d;
            edge_q     <= edge_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
`ifdef IO_TIMER_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign nib      = 4'(disp_q >> {idx_q, 2'b00});
    assign seg      = hex7(nib);
    assign digit_en = NUM_DIGITS'(1) << idx_q;

endmodule
